serial_adder_fsm: RTL and testbench

//  Bit-serial WIDTH-bit adder, built around a mux-based full-adder cell (two mux half adders).

---
 rtl/serial_add_pkg.sv | 23 ++
 rtl/mux_full_adder.sv | 23 ++
 rtl/serial_adder_fsm.sv | 143 ++++++++++++++
 tb/tb_serial_adder_fsm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types, limits and sizing helper for the bit-serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Bit counter only has to reach WIDTH-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_full_adder.sv
// rtl/mux_full_adder.sv - full adder from two 2:1-mux half adders plus an OR for carry
module mux_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  // Half adder as muxes: x selects between y and ~y for sum, between 0 and y for carry.
  assign w_s1 = a ? ~b : b;
  assign w_c1 = a ? b : 1'b0;

  assign s    = w_s1 ? ~cin : cin;
  assign w_c2 = w_s1 ? cin : 1'b0;

  assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_fsm.sv
// rtl/serial_adder_fsm.sv - LSB-first bit-serial adder/subtractor with valid/ready; SERIAL_SUB_EN adds sub port
module serial_adder_fsm
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_width_check
    $error("serial_adder_fsm: WIDTH out of range");
  end

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_release;
  logic             w_last;
  logic             w_bit_s;
  logic             w_bit_co;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_init;
  logic [WIDTH-1:0] w_sum_next;

  // Subtraction is a + ~b + 1: invert the addend and seed the carry.
`ifdef SERIAL_SUB_EN
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_init = sub;
`else
  assign w_b_load     = b;
  assign w_carry_init = 1'b0;
`endif

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state == ST_ADD) || (r_state == ST_DONE);
  assign sum        = r_sum;
  assign cout       = r_cout;

  assign w_accept   = in_valid && in_ready;
  assign w_release  = out_valid && out_ready;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_sum_next = {w_bit_s, r_sum_sr[WIDTH-1:1]};

  mux_full_adder u_fa (
    .a   (r_a_sr[0]),
    .b   (r_b_sr[0]),
    .cin (r_carry),
    .s   (w_bit_s),
    .co  (w_bit_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_release) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= w_b_load;
      r_sum_sr <= '0;
      r_carry  <= w_carry_init;
      r_cnt    <= '0;
    end else if (r_state == ST_ADD) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_next;
      r_carry  <= w_bit_co;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Result registers only change on the final serial bit, so they hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if ((r_state == ST_ADD) && w_last) begin
      r_sum  <= w_sum_next;
      r_cout <= w_bit_co;
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb/tb_serial_adder_fsm.sv - randomized and directed checks of serial_adder_fsm against a behavioural model
module tb_serial_adder_fsm;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid_i;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         out_valid;
  logic         out_ready_i;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
`ifdef SERIAL_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready_i),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural model: an operation is outstanding from its accept until its result
  // has been shown for at least one cycle and taken; the result is plain arithmetic.
  int           cyc = 0;
  bit           m_busy = 0;
  int           m_acc = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk) begin
    bit acc;
    bit rel;
    bit sv;
    logic [W:0] tmp;
    if (!rst_n) begin
      m_busy = 0;
    end else begin
      acc = in_valid_i && !m_busy;
      rel = m_busy && (cyc - m_acc >= W + 1) && out_ready_i;
      if (rel) m_busy = 0;
      if (acc) begin
        m_busy = 1;
        m_acc  = cyc;
`ifdef SERIAL_SUB_EN
        sv = sub_i;
`else
        sv = 1'b0;
`endif
        if (sv) begin
          m_sum  = a_i - b_i;
          m_cout = (a_i >= b_i);
        end else begin
          tmp    = {1'b0, a_i} + {1'b0, b_i};
          m_sum  = tmp[W-1:0];
          m_cout = tmp[W];
        end
      end
    end
    cyc++;
  end

  // Compare process: {in_ready, out_valid, busy, sum, cout}, result fields only when due.
  always @(negedge clk) begin
    logic [11:0] got;
    logic [11:0] exp;
    bit          show;
    show = 0;
    if (!rst_n) begin
      exp  = {3'b100, 8'h00, 1'b0};
      show = 1;
    end else if (!m_busy) begin
      exp = {3'b100, 9'h000};
    end else if (cyc - m_acc < W + 1) begin
      exp = {3'b001, 9'h000};
    end else begin
      exp  = {3'b011, m_sum, m_cout};
      show = 1;
    end
    got = {in_ready, out_valid, busy, show ? {sum, cout} : 9'h000};
    chk("cycle_model", {20'h0, got}, {20'h0, exp});
  end

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                    input int hold, input bit noise,
                    output logic [W-1:0] rs, output logic rc, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
    a_i         = av;
    b_i         = bv;
    sub_i       = sv;
    in_valid_i  = 1'b1;
    out_ready_i = (hold == 0);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    a_i        = W'($urandom);
    b_i        = W'($urandom);
    lat        = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      if (noise) begin
        in_valid_i = 1'($urandom_range(0, 1));
        a_i        = 8'h77;
      end
    end
    in_valid_i = 1'b0;
    if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
    rs = sum;
    rc = cout;
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", {31'h0, in_ready}, 32'd0);
      chk("hold_sum", {23'h0, sum, cout}, {23'h0, rs, rc});
      @(negedge clk);
    end
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = '0;
    b_i         = '0;
    sub_i       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {27'h0, in_ready, out_valid, busy, sum == 8'h00, cout}, {27'h0, 5'b10010});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    op(8'h00, 8'h00, 1'b0, 0, 0, rs, rc, lat);
    chk("t1_latency", lat, 32'd8);
    chk("t1_sum", {23'h0, rs, rc}, {23'h0, 8'h00, 1'b0});

    op(8'hFF, 8'h01, 1'b0, 0, 0, rs, rc, lat);
    chk("t2_sum", {23'h0, rs, rc}, {23'h0, 8'h00, 1'b1});

    op(8'h5A, 8'hA5, 1'b0, 3, 0, rs, rc, lat);
    chk("t3_sum", {23'h0, rs, rc}, {23'h0, 8'hFF, 1'b0});

    @(negedge clk);
    a_i        = 8'h12;
    b_i        = 8'h34;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_reset_in_ready", {30'h0, in_ready, out_valid}, {30'h0, 2'b10});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t4_no_out_valid", {30'h0, out_valid, in_ready}, {30'h0, 2'b01});
    end
    op(8'h03, 8'h04, 1'b0, 0, 0, rs, rc, lat);
    chk("t4_next_sum", {24'h0, rs}, {24'h0, 8'h07});

`ifdef SERIAL_SUB_EN
    op(8'h10, 8'h01, 1'b1, 0, 0, rs, rc, lat);
    chk("t5_sub_a", {23'h0, rs, rc}, {23'h0, 8'h0F, 1'b1});
    op(8'h01, 8'h02, 1'b1, 1, 0, rs, rc, lat);
    chk("t5_sub_b", {23'h0, rs, rc}, {23'h0, 8'hFF, 1'b0});
`endif

    op(8'h80, 8'h80, 1'b0, 0, 1, rs, rc, lat);
    chk("t6_b2b_first", {23'h0, rs, rc}, {23'h0, 8'h00, 1'b1});
    op(8'h7F, 8'h01, 1'b0, 0, 1, rs, rc, lat);
    chk("t6_b2b_second", {23'h0, rs, rc}, {23'h0, 8'h80, 1'b0});
    chk("t6_latency", lat, 32'd8);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic         sv;
      av = W'($urandom);
      bv = W'($urandom);
`ifdef SERIAL_SUB_EN
      sv = 1'($urandom_range(0, 1));
`else
      sv = 1'b0;
`endif
      op(av, bv, sv, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rs, rc, lat);
      chk("rand_latency", lat, 32'd8);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
